// File: rtl/crc_lane_engine.sv
// Multi-lane serial CRC generator/checker: accumulates one bit per lane per strobe, then shifts the CRC out MSB-first.
// Optional receive-side comparison of din against the outgoing CRC is enabled with `define CRC_CHECK_EN.
module crc_lane_engine #(
   parameter int unsigned     WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY = WIDTH'(16'h1021),
   parameter logic [WIDTH-1:0] INIT = '0,
   parameter int unsigned     LANES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     bit_en,
   input  logic [LANES-1:0]         din,
   input  logic                     emit,
   output logic [LANES-1:0]         dout,
   output logic                     dout_valid,
   output logic                     busy,
   output logic                     done,
   output logic [LANES*WIDTH-1:0]   crc,
   output logic [LANES-1:0]         err
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   crc_q [LANES];
   logic [WIDTH-1:0]   crc_d [LANES];
   logic [LANES-1:0]   dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef CRC_CHECK_EN
   logic [LANES-1:0]   err_q, err_d;
`endif

   // One MSB-first LFSR step of the CRC division.
   function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c, input logic b);
      logic inv;
      inv = b ^ c[WIDTH-1];
      return (c << 1) ^ (inv ? POLY : '0);
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
`ifdef CRC_CHECK_EN
      err_d        = err_q;
`endif
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         for (int unsigned i = 0; i < LANES; i++) crc_d[i] = INIT;
`ifdef CRC_CHECK_EN
         err_d   = '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bit_en) begin
                  for (int unsigned i = 0; i < LANES; i++) crc_d[i] = crc_step(crc_q[i], din[i]);
               end
               if (emit) begin
                  state_d = EMIT;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
`ifdef CRC_CHECK_EN
                  err_d   = '0;
`endif
               end
            end
            EMIT: begin
               // busy stays high through the cycle that carries done
               busy_d = 1'b1;
               if (bit_en) begin
                  dout_valid_d = 1'b1;
                  for (int unsigned i = 0; i < LANES; i++) begin
                     dout_d[i] = crc_q[i][WIDTH-1];
                     crc_d[i]  = crc_q[i] << 1;
`ifdef CRC_CHECK_EN
                     if (din[i] != crc_q[i][WIDTH-1]) err_d[i] = 1'b1;
`endif
                  end
                  if (cnt_q == CNT_LAST) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                     cnt_d   = '0;
                     for (int unsigned i = 0; i < LANES; i++) crc_d[i] = INIT;
                  end else begin
                     cnt_d = CNT_W'(cnt_q + 1'b1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) crc_q[i] <= INIT;
`ifdef CRC_CHECK_EN
         err_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         for (int unsigned i = 0; i < LANES; i++) crc_q[i] <= crc_d[i];
`ifdef CRC_CHECK_EN
         err_q        <= err_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

   for (genvar g = 0; g < LANES; g++) begin : g_crc_out
      assign crc[g*WIDTH +: WIDTH] = crc_q[g];
   end

`ifdef CRC_CHECK_EN
   assign err = err_q;
`else
   assign err = '0;
`endif

endmodule
